imem_boot: RTL and testbench

Parametrised, boot-loadable instruction memory for the pipelined RISC core's fetch stage.
- After reset it accepts a program as a valid/ready word stream, writing it at sequential addresses.
- It then switches to run mode and serves registered, one-cycle-latency instruction fetches.
- It replaces the fixed 8-bit-address, 16-bit-word, unloadable instruction store, and can be re-armed for a new program without a reset.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_ram.sv | 33 +++
 rtl/imem_boot.sv | 125 ++++++++++++
 tb/tb_imem_boot.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, default geometry and parity helper for the boot-loadable
// instruction memory.
package imem_pkg;

  typedef enum logic {
    IMEM_LOAD = 1'b0,
    IMEM_RUN  = 1'b1
  } imem_state_e;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_DATA_W = 16;
  localparam int IMEM_DEPTH  = 256;

  // Even parity over up to 64 bits; callers zero-extend narrower words.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// imem_ram: storage array, one synchronous write port and one registered read port (1-cycle
// latency); the read register holds its value when i_re is low, no backpressure.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // The array itself is never reset; only the output register is.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_boot.sv
// imem_boot: boot-loadable instruction memory; 1-cycle registered fetch, load stream ready only in LOAD.
// Optional IMEM_PARITY_EN stores an even-parity bit per word and drives parity_err on fetches.
module imem_boot
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  output logic              boot_done,
  output logic [ADDR_W:0]   ld_count,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              parity_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef IMEM_PARITY_EN
  localparam int MW = DATA_W + 1;
`else
  localparam int MW = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

  imem_state_e       r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_ld_ready;
  logic              r_boot_done;
  logic              r_vld;
  logic              r_oor;

  logic              w_accept;
  logic              w_in_range;
  logic              w_fetch;
  logic              w_re;
  logic [MW-1:0]     w_wdata;
  logic [MW-1:0]     w_rdata;

  assign w_accept   = (r_state == IMEM_LOAD) && ld_valid;
  assign w_in_range = {1'b0, fetch_addr} < DEPTH_V;
  // reload takes priority: a fetch issued alongside it is dropped.
  assign w_fetch    = (r_state == IMEM_RUN) && fetch_en && !reload;
  assign w_re       = w_fetch && w_in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IMEM_LOAD;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_ld_ready  <= 1'b1;
      r_boot_done <= 1'b0;
      r_vld       <= 1'b0;
      r_oor       <= 1'b0;
    end else begin
      case (r_state)
        IMEM_LOAD: begin
          r_vld <= 1'b0;
          if (ld_valid) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= r_cnt + 1'b1;
            if (ld_last || (r_ptr == LAST_PTR)) begin
              r_state     <= IMEM_RUN;
              r_ld_ready  <= 1'b0;
              r_boot_done <= 1'b1;
            end
          end
        end
        IMEM_RUN: begin
          r_vld <= w_fetch;
          if (w_fetch) r_oor <= !w_in_range;
          if (reload) begin
            r_state     <= IMEM_LOAD;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_ld_ready  <= 1'b1;
            r_boot_done <= 1'b0;
          end
        end
        default: r_state <= IMEM_LOAD;
      endcase
    end
  end

`ifdef IMEM_PARITY_EN
  assign w_wdata    = {even_par(64'(ld_data)), ld_data};
  assign parity_err = r_vld && !r_oor &&
                      (even_par(64'(w_rdata[DATA_W-1:0])) != w_rdata[DATA_W]);
`else
  assign w_wdata    = ld_data;
  assign parity_err = 1'b0;
`endif

  imem_ram #(
    .ADDR_W (IW),
    .WIDTH  (MW),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept),
    .i_waddr (r_ptr[IW-1:0]),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (fetch_addr[IW-1:0]),
    .o_rdata (w_rdata)
  );

  assign ld_ready    = r_ld_ready;
  assign boot_done   = r_boot_done;
  assign ld_count    = r_cnt;
  assign fetch_valid = r_vld;
  assign fetch_data  = r_oor ? '0 : w_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_imem_boot.sv
// tb_imem_boot: directed vectors against an 8-deep imem_boot; inputs change and outputs are
// sampled on the falling clock edge.
module tb_imem_boot;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int DP = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          reload;
  logic          boot_done;
  logic [AW:0]   ld_count;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_data;
  logic          fetch_valid;
  logic          parity_err;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic          exp_vld;
    logic [DW-1:0] exp_data;
  } fvec_t;

  fvec_t tv [9];

  imem_boot #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .reload      (reload),
    .boot_done   (boot_done),
    .ld_count    (ld_count),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string name);
    fetch_en   = 1'b1;
    fetch_addr = a;
    step();
    fetch_en   = 1'b0;
    chk({name, "_vld"}, 32'(fetch_valid), 32'd1);
    chk({name, "_dat"}, 32'(fetch_data), 32'(exp));
  endtask

  initial begin
    tv[0] = '{1'b1, 8'd0,  1'b1, 16'h1111};
    tv[1] = '{1'b1, 8'd1,  1'b1, 16'h2222};
    tv[2] = '{1'b1, 8'd2,  1'b1, 16'h3333};
    tv[3] = '{1'b1, 8'd3,  1'b1, 16'h4444};
    tv[4] = '{1'b0, 8'd0,  1'b0, 16'h4444};
    tv[5] = '{1'b1, 8'd9,  1'b1, 16'h0000};
    tv[6] = '{1'b0, 8'd1,  1'b0, 16'h0000};
    tv[7] = '{1'b1, 8'd2,  1'b1, 16'h3333};
    tv[8] = '{1'b1, 8'd15, 1'b1, 16'h0000};

    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    reload = 1'b0; fetch_en = 1'b0; fetch_addr = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ld_ready",    32'(ld_ready),    32'd1);
    chk("rst_boot_done",   32'(boot_done),   32'd0);
    chk("rst_ld_count",    32'(ld_count),    32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    chk("rst_fetch_data",  32'(fetch_data),  32'd0);
    chk("rst_parity_err",  32'(parity_err),  32'd0);
    rst_n = 1'b1;
    step();

    // Load with a gap cycle; fetch_en held high in LOAD must be ignored.
    fetch_en = 1'b1; fetch_addr = 8'd0;
    ld_valid = 1'b1; ld_data = 16'h1111; step();
    chk("load_cnt1", 32'(ld_count), 32'd1);
    chk("load_fetch_ignored", 32'(fetch_valid), 32'd0);
    ld_valid = 1'b0; ld_data = 16'hDEAD; step();
    chk("load_gap_cnt", 32'(ld_count), 32'd1);
    chk("load_gap_boot", 32'(boot_done), 32'd0);
    ld_valid = 1'b1; ld_data = 16'h2222; step();
    ld_data = 16'h3333; step();
    ld_data = 16'h4444; ld_last = 1'b1; step();
    ld_valid = 1'b0; ld_last = 1'b0; fetch_en = 1'b0;
    chk("boot_done_after_last", 32'(boot_done), 32'd1);
    chk("ld_count_4", 32'(ld_count), 32'd4);
    chk("ld_ready_run", 32'(ld_ready), 32'd0);

    // Fetch table; ld_valid is driven throughout RUN and must be ignored.
    ld_valid = 1'b1; ld_data = 16'hFFFF;
    for (int i = 0; i < 9; i++) begin
      fetch_en   = tv[i].en;
      fetch_addr = tv[i].addr;
      step();
      chk($sformatf("tv%0d_vld", i), 32'(fetch_valid), 32'(tv[i].exp_vld));
      chk($sformatf("tv%0d_dat", i), 32'(fetch_data), 32'(tv[i].exp_data));
    end
    ld_valid = 1'b0; fetch_en = 1'b0;
    chk("run_ld_count_hold", 32'(ld_count), 32'd4);

    // reload and fetch_en together: reload wins.
    reload = 1'b1; fetch_en = 1'b1; fetch_addr = 8'd0; step();
    reload = 1'b0; fetch_en = 1'b0;
    chk("reload_fetch_dropped", 32'(fetch_valid), 32'd0);
    chk("reload_ld_ready", 32'(ld_ready), 32'd1);
    chk("reload_boot_done", 32'(boot_done), 32'd0);
    chk("reload_ld_count", 32'(ld_count), 32'd0);
    ld_valid = 1'b1; ld_data = 16'hAAAA; step();
    ld_data = 16'h5555; ld_last = 1'b1; step();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("reload_boot", 32'(boot_done), 32'd1);
    chk("reload_cnt", 32'(ld_count), 32'd2);
    fetch(8'd0, 16'hAAAA, "rl_a0");
    fetch(8'd1, 16'h5555, "rl_a1");
    fetch(8'd2, 16'h3333, "rl_a2_old");

    // Overflow stop: 10 words, no ld_last, DEPTH 8.
    reload = 1'b1; step(); reload = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1'b1; ld_data = 16'h0100 + 16'(i);
      step();
      if (i == 7) begin
        chk("ovf_boot_done", 32'(boot_done), 32'd1);
        chk("ovf_cnt", 32'(ld_count), 32'd8);
      end
      if (i >= 8) begin
        chk($sformatf("ovf_ready_w%0d", i + 1), 32'(ld_ready), 32'd0);
        chk($sformatf("ovf_cnt_w%0d", i + 1), 32'(ld_count), 32'd8);
      end
    end
    ld_valid = 1'b0;
    fetch(8'd7, 16'h0107, "ovf_a7");
    fetch(8'd9, 16'h0000, "ovf_a9");
    fetch(8'd0, 16'h0100, "ovf_a0");
    fetch(8'd7, 16'h0107, "ovf_a7b");

    // Reset during a load: outputs clear asynchronously, next stream starts at 0.
    reload = 1'b1; step(); reload = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ld_valid = 1'b1; ld_data = 16'h0A00 + 16'(i); step();
    end
    ld_data = 16'h0A04;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(ld_count), 32'd0);
    chk("mid_rst_ready", 32'(ld_ready), 32'd1);
    chk("mid_rst_boot", 32'(boot_done), 32'd0);
    chk("mid_rst_fvld", 32'(fetch_valid), 32'd0);
    chk("mid_rst_fdat", 32'(fetch_data), 32'd0);
    ld_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    ld_valid = 1'b1; ld_data = 16'hBEEF; step();
    ld_data = 16'hCAFE; ld_last = 1'b1; step();
    ld_valid = 1'b0; ld_last = 1'b0;
    chk("post_rst_cnt", 32'(ld_count), 32'd2);
    chk("post_rst_boot", 32'(boot_done), 32'd1);
    fetch(8'd0, 16'hBEEF, "post_rst_a0");
    fetch(8'd1, 16'hCAFE, "post_rst_a1");

`ifdef IMEM_PARITY_EN
    u_dut.u_ram.r_mem[2][0] = ~u_dut.u_ram.r_mem[2][0];
    fetch(8'd2, 16'h0A02, "par_a2");
    chk("par_err_a2", 32'(parity_err), 32'd1);
    fetch(8'd1, 16'hCAFE, "par_a1");
    chk("par_ok_a1", 32'(parity_err), 32'd0);
    fetch(8'd9, 16'h0000, "par_a9");
    chk("par_oor", 32'(parity_err), 32'd0);
`else
    fetch(8'd2, 16'h0A03, "post_rst_a2");
    chk("par_const0", 32'(parity_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
